// File: rtl/sonic_echo_if.sv
// Trig/echo bundle between the sonic measurement front end (master) and the
// HC-SR04 responder (slave).
interface sonic_echo_if;
    logic       trig;
    logic [8:0] distance_cm;
    logic       echo;
    logic       busy;
    logic       short_trig;
    logic [7:0] trig_count;

    modport master (
        output trig,
        output distance_cm,
        input  echo,
        input  busy,
        input  short_trig,
        input  trig_count
    );

    modport slave (
        input  trig,
        input  distance_cm,
        output echo,
        output busy,
        output short_trig,
        output trig_count
    );
endinterface

// File: rtl/sonic_echo_emulator.sv
// Cycle-accurate HC-SR04 stand-in: validates the trig pulse width, waits out the
// burst delay, then returns an echo pulse whose width encodes distance_cm.
module sonic_echo_emulator #(
    parameter int unsigned CLK_PER_US   = 100,
    parameter int unsigned TRIG_MIN_CYC = 1000,
    parameter int unsigned BURST_US     = 200,
    parameter int unsigned US_PER_CM    = 59,
    parameter int unsigned MIN_CM       = 2,
    parameter int unsigned MAX_CM       = 400,
    parameter int unsigned TIMEOUT_US   = 38000,
    parameter int unsigned HOLDOFF_US   = 10000
) (
    input logic         clk,
    input logic         rst,
    sonic_echo_if.slave echo_bus
);

    localparam int unsigned PscW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StTrigHi  = 3'd1;
    localparam logic [2:0] StBurst   = 3'd2;
    localparam logic [2:0] StEcho    = 3'd3;
    localparam logic [2:0] StHoldoff = 3'd4;

    logic            trig_meta_q, trig_s_q, trig_d_q;
    logic [2:0]      state_q, state_d;
    logic [15:0]     width_q, width_d;
    logic [PscW-1:0] psc_q, psc_d;
    logic [15:0]     us_q, us_d;
    logic [15:0]     w_q, w_d;
    logic            echo_q, echo_d;
    logic            short_q, short_d;
    logic [7:0]      cnt_q, cnt_d;

    logic        rise, fall, us_tick;
    logic [15:0] w_calc;

    assign rise    = trig_s_q & ~trig_d_q;
    assign fall    = ~trig_s_q & trig_d_q;
    assign us_tick = (psc_q == PscW'(CLK_PER_US - 1));

    always_comb begin
        if (echo_bus.distance_cm < 9'(MIN_CM)) begin
            w_calc = 16'(MIN_CM * US_PER_CM);
        end else if (echo_bus.distance_cm > 9'(MAX_CM)) begin
            w_calc = 16'(TIMEOUT_US);
        end else begin
            w_calc = 16'(echo_bus.distance_cm) * 16'(US_PER_CM);
        end
    end

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;

        if (us_tick) begin
            psc_d = '0;
            us_d  = us_q + 16'd1;
        end else begin
            psc_d = psc_q + PscW'(1);
            us_d  = us_q;
        end

        case (state_q)
            StIdle: begin
                // The rise cycle itself is the first high cycle, so N high cycles count N.
                if (rise) begin
                    state_d = StTrigHi;
                    width_d = 16'd1;
                end
            end
            StTrigHi: begin
                if (fall) begin
                    if (width_q >= 16'(TRIG_MIN_CYC)) begin
                        w_d     = w_calc;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = StBurst;
                    end else begin
                        short_d = 1'b1;
                        state_d = StIdle;
                    end
                end else if (trig_s_q && (width_q != 16'hFFFF)) begin
                    width_d = width_q + 16'd1;
                end
            end
            StBurst: begin
                if (us_tick && (us_q == 16'(BURST_US - 1))) begin
                    state_d = StEcho;
                end
            end
            StEcho: begin
                if (us_tick && (us_q == w_q - 16'd1)) begin
                    state_d = StHoldoff;
                end
            end
            StHoldoff: begin
                if (us_tick && (us_q == 16'(HOLDOFF_US - 1))) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Timebase restarts on every state entry so each phase is exact.
        if (state_d != state_q) begin
            psc_d = '0;
            us_d  = '0;
        end

        echo_d = (state_d == StEcho);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_meta_q <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_d_q    <= 1'b0;
            state_q     <= StIdle;
            width_q     <= '0;
            psc_q       <= '0;
            us_q        <= '0;
            w_q         <= '0;
            echo_q      <= 1'b0;
            short_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            trig_meta_q <= echo_bus.trig;
            trig_s_q    <= trig_meta_q;
            trig_d_q    <= trig_s_q;
            state_q     <= state_d;
            width_q     <= width_d;
            psc_q       <= psc_d;
            us_q        <= us_d;
            w_q         <= w_d;
            echo_q      <= echo_d;
            short_q     <= short_d;
            cnt_q       <= cnt_d;
        end
    end

    assign echo_bus.echo       = echo_q;
    assign echo_bus.busy       = (state_q != StIdle);
    assign echo_bus.short_trig = short_q;
    assign echo_bus.trig_count = cnt_q;

endmodule

// File: tb/tb_sonic_echo_emulator.sv
// Directed bench for sonic_echo_emulator with scaled-down timing parameters:
// 4 clk/us, 40-cycle min trig, 20 us burst, 3 us/cm, 1300 us timeout, 100 us holdoff.
module tb_sonic_echo_emulator;

    localparam int unsigned CPU   = 4;
    localparam int unsigned TMIN  = 40;
    localparam int unsigned BURST = 20;
    localparam int unsigned UPC   = 3;
    localparam int unsigned MINC  = 2;
    localparam int unsigned MAXC  = 400;
    localparam int unsigned TOUT  = 1300;
    localparam int unsigned HOLD  = 100;

    // Hand-computed: delay 2 + 20*4, holdoff 100*4 cycles.
    localparam int ExpDelay   = 82;
    localparam int ExpHoldoff = 400;

    logic clk = 1'b0;
    logic rst;
    sonic_echo_if bus ();

    sonic_echo_emulator #(
        .CLK_PER_US  (CPU),
        .TRIG_MIN_CYC(TMIN),
        .BURST_US    (BURST),
        .US_PER_CM   (UPC),
        .MIN_CM      (MINC),
        .MAX_CM      (MAXC),
        .TIMEOUT_US  (TOUT),
        .HOLDOFF_US  (HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .echo_bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int trig_k  = 0;
    int rise_cyc = 0, echo_width = 0, echo_fall_cyc = 0, busy_fall_cyc = 0;
    int short_cyc = 0, short_hits = 0, pulse_cnt = 0, rise_cnt = 0;
    logic echo_p = 1'b0, busy_p = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Timestamps are edge indices: at the negedge after edge j, cyc == j.
    always @(negedge clk) begin
        echo_p <= bus.echo;
        busy_p <= bus.busy;
        if (bus.echo && !echo_p) begin
            rise_cyc <= cyc;
            rise_cnt <= rise_cnt + 1;
        end
        if (!bus.echo && echo_p) begin
            echo_width    <= cyc - rise_cyc;
            echo_fall_cyc <= cyc;
            pulse_cnt     <= pulse_cnt + 1;
        end
        if (!bus.busy && busy_p) busy_fall_cyc <= cyc;
        if (bus.short_trig) begin
            short_cyc  <= cyc;
            short_hits <= short_hits + 1;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Trig high for exactly n sampling edges; trig_k is the first edge sampling it low.
    task automatic do_trig(input int n);
        @(posedge clk);
        #1 bus.trig = 1'b1;
        repeat (n) @(posedge clk);
        #1 bus.trig = 1'b0;
        trig_k = cyc + 1;
    endtask

    task automatic wait_pulse(input int target, input int max_cyc, input string tag);
        int n = 0;
        while (pulse_cnt < target && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_echo_done"}, pulse_cnt, target);
    endtask

    task automatic wait_rise(input int target, input int max_cyc, input string tag);
        int n = 0;
        while (rise_cnt < target && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_echo_rise"}, rise_cnt, target);
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while (bus.busy && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #1;
        check_eq({tag, "_idle"}, int'(bus.busy), 0);
    endtask

    task automatic run_echo(input logic [8:0] d, input int exp_w, input int exp_cnt,
                            input string tag);
        int base;
        base = pulse_cnt;
        bus.distance_cm = d;
        do_trig(TMIN);
        wait_pulse(base + 1, 20000, tag);
        check_eq({tag, "_delay"}, rise_cyc - trig_k, ExpDelay);
        check_eq({tag, "_width"}, echo_width, exp_w);
        check_eq({tag, "_count"}, int'(bus.trig_count), exp_cnt);
        wait_idle(1000, tag);
        check_eq({tag, "_holdoff"}, busy_fall_cyc - echo_fall_cyc, ExpHoldoff);
    endtask

    task automatic short_case(input int n, input string tag);
        int hits0, pulses0;
        hits0   = short_hits;
        pulses0 = pulse_cnt;
        do_trig(n);
        repeat (10) @(posedge clk);
        #1;
        check_eq({tag, "_short_hits"}, short_hits - hits0, 1);
        check_eq({tag, "_short_at"}, short_cyc - trig_k, 2);
        check_eq({tag, "_no_echo"}, pulse_cnt - pulses0, 0);
        check_eq({tag, "_count"}, int'(bus.trig_count), 1);
        check_eq({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        int base, rbase, hits0;

        rst             = 1'b1;
        bus.trig        = 1'b0;
        bus.distance_cm = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_echo", int'(bus.echo), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_short", int'(bus.short_trig), 0);
        check_eq("rst_count", int'(bus.trig_count), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Minimum-width trig, 10 cm: 30 us -> 120 cycles.
        bus.distance_cm = 9'd10;
        base = pulse_cnt;
        do_trig(TMIN);
        check_eq("t1_busy_in_trig", int'(bus.busy), 1);
        wait_pulse(base + 1, 2000, "t1");
        check_eq("t1_delay", rise_cyc - trig_k, ExpDelay);
        check_eq("t1_width", echo_width, 120);
        check_eq("t1_count", int'(bus.trig_count), 1);
        wait_idle(1000, "t1");
        check_eq("t1_holdoff", busy_fall_cyc - echo_fall_cyc, ExpHoldoff);

        short_case(TMIN - 1, "short39");
        short_case(1, "glitch");

        // 0 cm clamps to 2 cm: 6 us; 400 cm: 1200 us.
        run_echo(9'd0, 24, 2, "d0");
        run_echo(9'd400, 4800, 3, "d400");

        // 450 cm times out (1300 us); trigs mid-ECHO and mid-HOLDOFF are ignored.
        bus.distance_cm = 9'd450;
        base  = pulse_cnt;
        rbase = rise_cnt;
        hits0 = short_hits;
        do_trig(TMIN);
        wait_rise(rbase + 1, 200, "d450");
        repeat (100) @(posedge clk);
        do_trig(TMIN);
        check_eq("d450_ign_echo_cnt", int'(bus.trig_count), 4);
        wait_pulse(base + 1, 20000, "d450");
        check_eq("d450_width", echo_width, 5200);
        repeat (50) @(posedge clk);
        do_trig(TMIN);
        wait_idle(1000, "d450");
        check_eq("d450_ign_hold_cnt", int'(bus.trig_count), 4);
        check_eq("d450_ign_short", short_hits - hits0, 0);
        check_eq("d450_holdoff", busy_fall_cyc - echo_fall_cyc, ExpHoldoff);

        // Trig after busy falls is accepted; 1 cm clamps to 6 us.
        run_echo(9'd1, 24, 5, "d1");

        // Distance changed during BURST must not affect the latched width.
        bus.distance_cm = 9'd10;
        base = pulse_cnt;
        do_trig(TMIN);
        repeat (10) @(posedge clk);
        bus.distance_cm = 9'd300;
        wait_pulse(base + 1, 2000, "chg");
        check_eq("chg_width", echo_width, 120);
        check_eq("chg_count", int'(bus.trig_count), 6);
        wait_idle(1000, "chg");

        // Reset mid-ECHO.
        bus.distance_cm = 9'd450;
        rbase = rise_cnt;
        do_trig(TMIN);
        wait_rise(rbase + 1, 200, "rst");
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_echo", int'(bus.echo), 0);
        check_eq("midrst_count", int'(bus.trig_count), 0);
        check_eq("midrst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        run_echo(9'd10, 120, 1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
